// File: rtl/mc_ctrl_pkg.sv
// Shared encodings between the multicycle controller and datapath: ALU ops,
// operand/result/address select codes, IR field positions and OP classes.
package mc_ctrl_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_ORR = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_CLR = 4'b0101,
        ALU_ROL = 4'b0110,
        ALU_ROR = 4'b0111,
        ALU_LSL = 4'b1000,
        ALU_LSR = 4'b1001,
        ALU_ASR = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_REG  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_ONE  = 2'b10,
        SRCB_ZERO = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_DR     = 2'b01,
        RES_ALU    = 2'b10,
        RES_IMM    = 2'b11
    } result_src_e;

    // AdrSrc: only 01 selects Result, both 00 and 1x select PC
    localparam logic [1:0] ADR_RESULT = 2'b01;

    localparam int REGSRC_RA1_RN = 2;
    localparam int REGSRC_RA2_RD = 1;
    localparam int REGSRC_LINK   = 0;

    localparam int IR_OP_LSB   = 14;
    localparam int IR_TYPE_LSB = 11;
    localparam int IR_RD_LSB   = 8;
    localparam int IR_RN_LSB   = 5;
    localparam int IR_RM_LSB   = 2;
    localparam int IR_COND_LSB = 0;

    localparam logic [1:0] OP_DP     = 2'b00;
    localparam logic [1:0] OP_MEM    = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;
    localparam logic [1:0] OP_IMM    = 2'b11;

    localparam logic [2:0] LINK_REG = 3'd7;

    function automatic logic [WORD_W-1:0] imm_extend(input logic [7:0] imm_field,
                                                     input logic       imm_src);
        return imm_src ? {8'd0, imm_field} : {11'd0, imm_field[4:0]};
    endfunction

endpackage

// File: rtl/multicycle_datapath_if.sv
// Unified instruction/data memory bus; the datapath is the master, memory the slave.
interface multicycle_datapath_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
    modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

// File: rtl/mc_alu.sv
// Combinational 16-bit ALU producing the result and {N,Z,C,V} flags.
module mc_alu
    import mc_ctrl_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [3:0]        alu_control,
    output logic [WORD_W-1:0] result,
    output logic [3:0]        flags
);

    logic [16:0] sum;
    logic [16:0] diff;
    logic [3:0]  shamt;
    logic [16:0] lsl_t;
    logic [16:0] lsr_t;
    logic [16:0] asr_t;
    logic [31:0] rol_t;
    logic [31:0] ror_t;
    logic        carry;
    logic        ovf;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        shamt  = b[3:0];
        // The extra guard bit on each shift catches the last bit shifted out
        lsl_t  = {1'b0, a} << shamt;
        lsr_t  = {a, 1'b0} >> shamt;
        asr_t  = 17'($signed({a, 1'b0}) >>> shamt);
        rol_t  = {a, a} << shamt;
        ror_t  = {a, a} >> shamt;
        result = a;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (alu_control)
            ALU_ADD: begin
                result = sum[15:0];
                carry  = sum[16];
                ovf    = (a[15] == b[15]) && (sum[15] != a[15]);
            end
            ALU_SUB: begin
                result = diff[15:0];
                carry  = ~diff[16];
                ovf    = (a[15] != b[15]) && (diff[15] != a[15]);
            end
            ALU_AND: result = a & b;
            ALU_ORR: result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_CLR: result = '0;
            ALU_ROL: begin
                result = rol_t[31:16];
                carry  = (shamt != 4'd0) && rol_t[16];
            end
            ALU_ROR: begin
                result = ror_t[15:0];
                carry  = (shamt != 4'd0) && ror_t[15];
            end
            ALU_LSL: begin
                result = lsl_t[15:0];
                carry  = lsl_t[16];
            end
            ALU_LSR: begin
                result = lsr_t[16:1];
                carry  = lsr_t[0];
            end
            ALU_ASR: begin
                result = asr_t[16:1];
                carry  = asr_t[0];
            end
            default: begin
                result = a;
                carry  = 1'b0;
                ovf    = 1'b0;
            end
        endcase
        flags = {result[15], (result == '0), carry, ovf};
    end

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle datapath: PC, IR, DR, A, B, ALUOut and an 8x16 register file steered by a per-cycle control word.
// Defining DATAPATH_DEBUG_EN adds dbg_sel/dbg_reg/dbg_pc observation ports.
module multicycle_datapath
    import mc_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        PCWrite,
    input  logic [1:0]  AdrSrc,
    input  logic        MemWrite,
    input  logic        IRWrite,
    input  logic [2:0]  RegSrc,
    input  logic        RegWrite,
    input  logic        ImmSrc,
    input  logic        ALUSrcA,
    input  logic [1:0]  ALUSrcB,
    input  logic [3:0]  ALUControl,
    input  logic [1:0]  ResultSrc,
    output logic [1:0]  OP,
    // "type" is a reserved word, so the IR[13:11] field is exposed as Type
    output logic [2:0]  Type,
    output logic [2:0]  Rd,
    output logic [1:0]  cond,
    output logic [3:0]  flags,
`ifdef DATAPATH_DEBUG_EN
    input  logic [2:0]  dbg_sel,
    output logic [15:0] dbg_reg,
    output logic [15:0] dbg_pc,
`endif
    multicycle_datapath_if.master mem
);

    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] dr_q, dr_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] alu_out_q, alu_out_d;
    logic [DATA_W-1:0] rf_q [8];
    logic [DATA_W-1:0] rf_d [8];

    logic [2:0]        rn_f, rm_f, rd_f, wa;
    logic [DATA_W-1:0] rd1, rd2, wd;
    logic [DATA_W-1:0] imm_ext, src_a, src_b, alu_result, result, adr_sel;

    always_comb begin
        rd_f    = ir_q[IR_RD_LSB +: 3];
        rn_f    = ir_q[IR_RN_LSB +: 3];
        rm_f    = ir_q[IR_RM_LSB +: 3];
        imm_ext = imm_extend(ir_q[7:0], ImmSrc);
        rd1     = RegSrc[REGSRC_RA1_RN] ? rf_q[rn_f] : pc_q;
        rd2     = rf_q[RegSrc[REGSRC_RA2_RD] ? rd_f : rm_f];
        src_a   = ALUSrcA ? pc_q : a_q;
        case (ALUSrcB)
            SRCB_REG: src_b = b_q;
            SRCB_IMM: src_b = imm_ext;
            SRCB_ONE: src_b = 16'd1;
            default:  src_b = '0;
        endcase
    end

    mc_alu u_alu (
        .a           (src_a),
        .b           (src_b),
        .alu_control (ALUControl),
        .result      (alu_result),
        .flags       (flags)
    );

    always_comb begin
        case (ResultSrc)
            RES_ALUOUT: result = alu_out_q;
            RES_DR:     result = dr_q;
            RES_ALU:    result = alu_result;
            default:    result = imm_ext;
        endcase
        // Link writes capture the pre-edge PC, i.e. the return address
        wa      = RegSrc[REGSRC_LINK] ? LINK_REG : rd_f;
        wd      = RegSrc[REGSRC_LINK] ? pc_q : result;
        adr_sel = (AdrSrc == ADR_RESULT) ? result : pc_q;
    end

    always_comb begin
        pc_d      = PCWrite ? result : pc_q;
        ir_d      = IRWrite ? mem.mem_rdata : ir_q;
        dr_d      = mem.mem_rdata;
        a_d       = rd1;
        b_d       = rd2;
        alu_out_d = alu_result;
        for (int i = 0; i < 8; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (RegWrite) begin
            rf_d[wa] = wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q      <= '0;
            ir_q      <= '0;
            dr_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            dr_q      <= dr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign OP            = ir_q[IR_OP_LSB +: 2];
    assign Type          = ir_q[IR_TYPE_LSB +: 3];
    assign Rd            = rd_f;
    assign cond          = ir_q[IR_COND_LSB +: 2];
    assign mem.mem_addr  = adr_sel[ADDR_W-1:0];
    assign mem.mem_wdata = b_q;
    assign mem.mem_we    = MemWrite;

`ifdef DATAPATH_DEBUG_EN
    assign dbg_reg = rf_q[dbg_sel];
    assign dbg_pc  = pc_q;
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed testbench for multicycle_datapath: the bench plays controller and memory,
// stepping instruction sequences cycle by cycle and checking hand-computed values.
module tb_multicycle_datapath;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        PCWrite;
    logic [1:0]  AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic [2:0]  RegSrc;
    logic        RegWrite;
    logic        ImmSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [3:0]  ALUControl;
    logic [1:0]  ResultSrc;
    logic [1:0]  OP;
    logic [2:0]  Type;
    logic [2:0]  Rd;
    logic [1:0]  cond;
    logic [3:0]  flags;
`ifdef DATAPATH_DEBUG_EN
    logic [2:0]  dbg_sel = 3'd0;
    logic [15:0] dbg_reg;
    logic [15:0] dbg_pc;
`endif

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_pc;

    multicycle_datapath_if mem_bus ();

    always #5 clk = ~clk;

    multicycle_datapath dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegSrc     (RegSrc),
        .RegWrite   (RegWrite),
        .ImmSrc     (ImmSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ResultSrc  (ResultSrc),
        .OP         (OP),
        .Type       (Type),
        .Rd         (Rd),
        .cond       (cond),
        .flags      (flags),
`ifdef DATAPATH_DEBUG_EN
        .dbg_sel    (dbg_sel),
        .dbg_reg    (dbg_reg),
        .dbg_pc     (dbg_pc),
`endif
        .mem        (mem_bus)
    );

    task automatic clearCtrl();
        PCWrite    = 1'b0;
        AdrSrc     = 2'b00;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegSrc     = 3'b000;
        RegWrite   = 1'b0;
        ImmSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 4'b0000;
        ResultSrc  = 2'b00;
    endtask

    // One clock with the current control word, then back to an idle word
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        clearCtrl();
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic fetch(input logic [15:0] instr);
        mem_bus.mem_rdata = instr;
        PCWrite    = 1'b1;
        IRWrite    = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = 4'b0000;
        ResultSrc  = 2'b10;
        AdrSrc     = 2'b00;
        #1;
        checkOutput("fetch_addr", mem_bus.mem_addr, exp_pc);
        applyStimulus();
        exp_pc = exp_pc + 16'd1;
        checkOutput("pc_after_fetch", mem_bus.mem_addr, exp_pc);
        checkOutput("ir_fields", {6'd0, OP, Type, Rd, cond}, {6'd0, instr[15:8], instr[1:0]});
    endtask

    task automatic ldiStep();
        RegWrite  = 1'b1;
        ImmSrc    = 1'b1;
        ResultSrc = 2'b11;
        applyStimulus();
    endtask

    // Register R[Rd] of the current IR reaches mem_wdata through the B register
    task automatic readRd(input string tag, input logic [15:0] expected);
        RegSrc = 3'b010;
        applyStimulus();
        checkOutput(tag, mem_bus.mem_wdata, expected);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        clearCtrl();
        reset_n = 1'b0;
        exp_pc  = 16'd0;
        mem_bus.mem_rdata = 16'($urandom);

        // Reset with arbitrary control words
        repeat (2) begin
            {PCWrite, AdrSrc, MemWrite, IRWrite, RegSrc, RegWrite, ImmSrc,
             ALUSrcA, ALUSrcB, ALUControl, ResultSrc} = 19'($urandom);
            mem_bus.mem_rdata = 16'($urandom);
            @(posedge clk);
            #1;
        end
        clearCtrl();
        #1;
        checkOutput("reset_mem_addr", mem_bus.mem_addr, 16'h0000);
        checkOutput("reset_ir_fields", {6'd0, OP, Type, Rd, cond}, 16'h0000);
        checkOutput("reset_mem_wdata", mem_bus.mem_wdata, 16'h0000);
        checkOutput("reset_mem_we", {15'd0, mem_bus.mem_we}, 16'h0000);
        checkOutput("reset_flags", {12'd0, flags}, 16'h0004);
        reset_n = 1'b1;

        // Fetch: OP=00 type=000 Rd=5 cond=00, PC 0 -> 1
        fetch(16'h0534);

        // ldi R1,5 ; ldi R2,7
        fetch(16'hC105);
        ldiStep();
        fetch(16'hC207);
        ldiStep();

        // add R3,R1,R2
        fetch(16'h0328);
        RegSrc = 3'b100;
        applyStimulus();
        RegSrc = 3'b100;
        ALUControl = 4'b0000;
        ResultSrc = 2'b10;
        AdrSrc = 2'b01;
        #1;
        checkOutput("add_result", mem_bus.mem_addr, 16'd12);
        checkOutput("add_flags", {12'd0, flags}, 16'h0000);
        applyStimulus();
        ResultSrc = 2'b00;
        RegWrite = 1'b1;
        applyStimulus();

        // sub R3,R3,R3 : zero result with no borrow
        fetch(16'h036C);
        RegSrc = 3'b100;
        applyStimulus();
        checkOutput("r3_after_add", mem_bus.mem_wdata, 16'd12);
        RegSrc = 3'b100;
        ALUControl = 4'b0001;
        #1;
        checkOutput("sub_flags", {12'd0, flags}, 16'h0006);
        applyStimulus();

        // str R3,[R1+4]
        fetch(16'h4324);
        RegSrc = 3'b110;
        applyStimulus();
        RegSrc = 3'b110;
        ALUSrcB = 2'b01;
        ImmSrc = 1'b0;
        applyStimulus();
        RegSrc = 3'b110;
        AdrSrc = 2'b01;
        ResultSrc = 2'b00;
        MemWrite = 1'b1;
        #1;
        checkOutput("str_we", {15'd0, mem_bus.mem_we}, 16'h0001);
        checkOutput("str_addr", mem_bus.mem_addr, 16'd9);
        checkOutput("str_wdata", mem_bus.mem_wdata, 16'd12);
        applyStimulus();

        // ldr R4,[R1+4] : fetch, decode, exec, mem, writeback
        fetch(16'h4424);
        RegSrc = 3'b100;
        applyStimulus();
        RegSrc = 3'b100;
        ALUSrcB = 2'b01;
        applyStimulus();
        AdrSrc = 2'b01;
        ResultSrc = 2'b00;
        mem_bus.mem_rdata = 16'd12;
        #1;
        checkOutput("ldr_addr", mem_bus.mem_addr, 16'd9);
        checkOutput("ldr_we", {15'd0, mem_bus.mem_we}, 16'h0000);
        applyStimulus();
        mem_bus.mem_rdata = 16'hDEAD;
        ResultSrc = 2'b01;
        RegWrite = 1'b1;
        applyStimulus();
        readRd("r4_after_ldr", 16'd12);

        // Two nops bring PC to 9, so bl is fetched from 9 and PC becomes 10
        fetch(16'h0000);
        fetch(16'h0000);
        fetch(16'h8705);
        checkOutput("pc_before_bl", mem_bus.mem_addr, 16'd10);
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b01;
        ImmSrc = 1'b1;
        ALUControl = 4'b0000;
        ResultSrc = 2'b10;
        PCWrite = 1'b1;
        RegWrite = 1'b1;
        RegSrc = 3'b001;
        applyStimulus();
        exp_pc = 16'd15;
        checkOutput("bl_target", mem_bus.mem_addr, 16'd15);
        readRd("r7_link", 16'd10);

        // ldi R6,0xA5
        fetch(16'hC6A5);
        RegWrite = 1'b1;
        ImmSrc = 1'b1;
        ResultSrc = 2'b11;
        AdrSrc = 2'b01;
        #1;
        checkOutput("ldi_result", mem_bus.mem_addr, 16'h00A5);
        applyStimulus();
        readRd("r6_ldi", 16'h00A5);

        // Build 0x8001 in R5: ldi 1, lsl #15, orr #1
        fetch(16'hC501);
        ldiStep();
        fetch(16'h05AF);
        RegSrc = 3'b100;
        applyStimulus();
        RegSrc = 3'b100;
        ALUSrcB = 2'b01;
        ImmSrc = 1'b0;
        ALUControl = 4'b1000;
        ResultSrc = 2'b10;
        AdrSrc = 2'b01;
        #1;
        checkOutput("lsl15_result", mem_bus.mem_addr, 16'h8000);
        checkOutput("lsl15_flags", {12'd0, flags}, 16'h0008);
        applyStimulus();
        RegWrite = 1'b1;
        applyStimulus();
        RegSrc = 3'b100;
        applyStimulus();
        ALUSrcB = 2'b10;
        ALUControl = 4'b0011;
        ResultSrc = 2'b10;
        AdrSrc = 2'b01;
        #1;
        checkOutput("orr1_result", mem_bus.mem_addr, 16'h8001);
        applyStimulus();
        RegWrite = 1'b1;
        applyStimulus();
        RegSrc = 3'b100;
        applyStimulus();

        // A=0x8001 against constant 1 for several ops
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
        AdrSrc = 2'b01;
        ALUControl = 4'b1010;
        #1;
        checkOutput("asr1_result", mem_bus.mem_addr, 16'hC000);
        checkOutput("asr1_flags", {12'd0, flags}, 16'h000A);
        ALUControl = 4'b0110;
        #1;
        checkOutput("rol1_result", mem_bus.mem_addr, 16'h0003);
        checkOutput("rol1_flags", {12'd0, flags}, 16'h0002);
        ALUControl = 4'b1111;
        #1;
        checkOutput("undef_op_result", mem_bus.mem_addr, 16'h8001);
        checkOutput("undef_op_flags", {12'd0, flags}, 16'h0008);
        applyStimulus();

        // Reset lands on the writeback edge of an ldr
        fetch(16'h4424);
        RegSrc = 3'b100;
        applyStimulus();
        RegSrc = 3'b100;
        ALUSrcB = 2'b01;
        applyStimulus();
        AdrSrc = 2'b01;
        mem_bus.mem_rdata = 16'h1234;
        applyStimulus();
        reset_n = 1'b0;
        ResultSrc = 2'b01;
        RegWrite = 1'b1;
        PCWrite = 1'b1;
        applyStimulus();
        reset_n = 1'b1;
        exp_pc = 16'd0;
        checkOutput("midldr_pc", mem_bus.mem_addr, 16'h0000);
        checkOutput("midldr_ir_fields", {6'd0, OP, Type, Rd, cond}, 16'h0000);
        checkOutput("midldr_wdata", mem_bus.mem_wdata, 16'h0000);
        fetch(16'h0400);
        readRd("midldr_r4", 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
